// File: rtl/vend_pkg.sv
// Shared definitions for the vending coin-return path.
//   - change request encodings (5-cent units)
//   - dispenser FSM state enum
//   - coin values in 5-cent units
package vend_pkg;

    typedef enum logic [1:0] {
        CHG_NONE = 2'b00,
        CHG_5    = 2'b01,
        CHG_10   = 2'b10,
        CHG_15   = 2'b11
    } chg_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        EJECT     = 3'd2,
        WAIT_DROP = 3'd3,
        FAULT     = 3'd4
    } disp_state_e;

    localparam logic [1:0] NICKEL_UNITS = 2'd1;
    localparam logic [1:0] DIME_UNITS   = 2'd2;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter with a terminal flag.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load_i        load count with load_val_i (has priority over counting)
//   load_val_i    value loaded; the flag asserts load_val_i cycles later
//   done_o        high while the count is zero
// Loading N-1 gives a window of exactly N cycles ending with done_o high.
module pulse_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return back end: accepts a change request over valid/ready and pays
// it out one coin at a time via nickel/dime solenoids, waiting for the
// drop sensor after each ejection. Tracks inventory; faults with the unpaid
// amount when change cannot be made or a coin does not drop.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake, req_change in 5c units
//   drop_sense                coin-drop sensor
//   refill                    reload inventories (IDLE and FAULT only)
//   eject_nickel/eject_dime   solenoid drives
//   busy, fault, owed         status; owed valid while fault is high
//   nickel_empty, dime_empty  inventory-empty flags
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int DROP_TIMEOUT = 16,
    parameter int INV_W        = 8,
    parameter int INIT_NICKELS = 20,
    parameter int INIT_DIMES   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_change,
    input  logic       drop_sense,
    input  logic       refill,
    output logic       eject_nickel,
    output logic       eject_dime,
    output logic       busy,
    output logic       fault,
    output logic [1:0] owed,
    output logic       nickel_empty,
    output logic       dime_empty
);

    localparam int TMAX = (PULSE_CYCLES > DROP_TIMEOUT) ? PULSE_CYCLES : DROP_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    DROP_LOAD  = TW'(DROP_TIMEOUT - 1);
    localparam logic [INV_W-1:0] INIT_N     = INV_W'(INIT_NICKELS);
    localparam logic [INV_W-1:0] INIT_D     = INV_W'(INIT_DIMES);

    disp_state_e      state_q, state_d;
    logic [1:0]       remaining_q, remaining_d;
    logic             coin_dime_q, coin_dime_d;
    logic             drop_seen_q, drop_seen_d;
    logic [INV_W-1:0] nickels_q, nickels_d;
    logic [INV_W-1:0] dimes_q, dimes_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_done;
    logic          coin_confirmed;

    // One timer serves both the solenoid on-time and the drop timeout; it is
    // reloaded on every entry into EJECT (from SELECT) and into WAIT_DROP.
    pulse_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        coin_dime_d    = coin_dime_q;
        drop_seen_d    = drop_seen_q;
        nickels_d      = nickels_q;
        dimes_d        = dimes_q;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;
        coin_confirmed = 1'b0;

        case (state_q)
            IDLE: begin
                if (refill) begin
                    nickels_d = INIT_N;
                    dimes_d   = INIT_D;
                end
                // A zero-value request is accepted but needs no payout.
                if (req_valid && (req_change != CHG_NONE)) begin
                    remaining_d = req_change;
                    state_d     = SELECT;
                end
            end
            SELECT: begin
                drop_seen_d  = 1'b0;
                tmr_load     = 1'b1;
                tmr_load_val = PULSE_LOAD;
                if (remaining_q == 2'd0) begin
                    state_d = IDLE;
                end else if ((remaining_q >= DIME_UNITS) && (dimes_q != '0)) begin
                    coin_dime_d = 1'b1;
                    state_d     = EJECT;
                end else if (nickels_q != '0) begin
                    coin_dime_d = 1'b0;
                    state_d     = EJECT;
                end else begin
                    state_d = FAULT;
                end
            end
            EJECT: begin
                if (drop_sense) begin
                    drop_seen_d = 1'b1;
                end
                if (tmr_done) begin
                    // Include the last cycle's own sample in the decision.
                    if (drop_seen_q || drop_sense) begin
                        coin_confirmed = 1'b1;
                    end else begin
                        state_d      = WAIT_DROP;
                        tmr_load     = 1'b1;
                        tmr_load_val = DROP_LOAD;
                    end
                end
            end
            WAIT_DROP: begin
                if (drop_sense) begin
                    coin_confirmed = 1'b1;
                end else if (tmr_done) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (refill) begin
                    nickels_d = INIT_N;
                    dimes_d   = INIT_D;
                    state_d   = SELECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Coin confirmed: charge it against inventory and the amount owed.
        if (coin_confirmed) begin
            state_d      = SELECT;
            drop_seen_d  = 1'b0;
            tmr_load     = 1'b1;
            tmr_load_val = '0;
            if (coin_dime_q) begin
                dimes_d     = dimes_q - INV_W'(1);
                remaining_d = remaining_q - DIME_UNITS;
            end else begin
                nickels_d   = nickels_q - INV_W'(1);
                remaining_d = remaining_q - NICKEL_UNITS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= 2'd0;
            coin_dime_q <= 1'b0;
            drop_seen_q <= 1'b0;
            nickels_q   <= INIT_N;
            dimes_q     <= INIT_D;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_dime_q <= coin_dime_d;
            drop_seen_q <= drop_seen_d;
            nickels_q   <= nickels_d;
            dimes_q     <= dimes_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign fault        = (state_q == FAULT);
    assign owed         = fault ? remaining_q : 2'b00;
    assign eject_nickel = (state_q == EJECT) && !coin_dime_q;
    assign eject_dime   = (state_q == EJECT) && coin_dime_q;
    assign nickel_empty = (nickels_q == '0);
    assign dime_empty   = (dimes_q == '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser. Three instances: default
// inventories, no dimes, no nickels. Stimulus pushes expected events
// (coin pulse, request done, fault entry); a negedge monitor pops/compares.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int NDUT = 3;
    localparam int S_EJN = 0, S_EJD = 1, S_BUSY = 2, S_FAULT = 3;

    typedef enum int {EV_COIN, EV_DONE, EV_FAULT} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        bit       dime;
        int       len;
        int       owed;
        int       nick;
        int       dcnt;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NDUT-1:0]      req_valid  = '0;
    logic [NDUT-1:0]      req_ready;
    logic [NDUT-1:0][1:0] req_change = '0;
    logic [NDUT-1:0]      drop_sense = '0;
    logic [NDUT-1:0]      refill     = '0;
    logic [NDUT-1:0]      eject_nickel, eject_dime, busy, fault;
    logic [NDUT-1:0][1:0] owed;
    logic [NDUT-1:0]      nickel_empty, dime_empty;
    logic [NDUT-1:0][7:0] inv_n, inv_d;

    int n_checks = 0;
    int n_fail   = 0;
    ev_t exp_q0[$], exp_q1[$], exp_q2[$];

    always #5 clk = ~clk;

    change_dispenser u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_change(req_change[0]), .drop_sense(drop_sense[0]), .refill(refill[0]),
        .eject_nickel(eject_nickel[0]), .eject_dime(eject_dime[0]), .busy(busy[0]),
        .fault(fault[0]), .owed(owed[0]), .nickel_empty(nickel_empty[0]),
        .dime_empty(dime_empty[0]));

    change_dispenser #(.INIT_DIMES(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_change(req_change[1]), .drop_sense(drop_sense[1]), .refill(refill[1]),
        .eject_nickel(eject_nickel[1]), .eject_dime(eject_dime[1]), .busy(busy[1]),
        .fault(fault[1]), .owed(owed[1]), .nickel_empty(nickel_empty[1]),
        .dime_empty(dime_empty[1]));

    change_dispenser #(.INIT_NICKELS(0)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_change(req_change[2]), .drop_sense(drop_sense[2]), .refill(refill[2]),
        .eject_nickel(eject_nickel[2]), .eject_dime(eject_dime[2]), .busy(busy[2]),
        .fault(fault[2]), .owed(owed[2]), .nickel_empty(nickel_empty[2]),
        .dime_empty(dime_empty[2]));

    assign inv_n[0] = u_dut0.nickels_q;
    assign inv_d[0] = u_dut0.dimes_q;
    assign inv_n[1] = u_dut1.nickels_q;
    assign inv_d[1] = u_dut1.dimes_q;
    assign inv_n[2] = u_dut2.nickels_q;
    assign inv_d[2] = u_dut2.dimes_q;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic ev_t mk(ev_kind_e k, bit dm, int ln, int ow, int nk, int dc);
        ev_t e;
        e.kind = k; e.dime = dm; e.len = ln; e.owed = ow; e.nick = nk; e.dcnt = dc;
        return e;
    endfunction

    function automatic void push_ev(int d, ev_t e);
        case (d)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endfunction

    function automatic void pop_cmp(int d, ev_t o);
        ev_t e;
        bit  have = 1'b0;
        case (d)
            0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
        endcase
        $display("dut%0d event kind=%0d dime=%0d len=%0d owed=%0d inv=%0d/%0d",
                 d, o.kind, o.dime, o.len, o.owed, o.nick, o.dcnt);
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d unexpected event: got kind %0d, expected none", d, o.kind);
            return;
        end
        check($sformatf("dut%0d event kind", d), o.kind, e.kind);
        if (o.kind != e.kind) return;
        case (e.kind)
            EV_COIN: begin
                check($sformatf("dut%0d coin is dime", d), o.dime, e.dime);
                check($sformatf("dut%0d pulse length", d), o.len, e.len);
            end
            EV_FAULT: begin
                check($sformatf("dut%0d owed", d), o.owed, e.owed);
                check($sformatf("dut%0d fault nickels", d), o.nick, e.nick);
                check($sformatf("dut%0d fault dimes", d), o.dcnt, e.dcnt);
            end
            default: begin
                check($sformatf("dut%0d done nickels", d), o.nick, e.nick);
                check($sformatf("dut%0d done dimes", d), o.dcnt, e.dcnt);
            end
        endcase
    endfunction

    // Monitor: converts DUT output activity into events.
    initial begin
        int  plen [NDUT];
        bit  pdime [NDUT];
        bit  busy_prev [NDUT];
        bit  fault_prev [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            plen[d] = 0; pdime[d] = 1'b0; busy_prev[d] = 1'b0; fault_prev[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                if (eject_nickel[d] === 1'b1 || eject_dime[d] === 1'b1) begin
                    plen[d]++;
                    pdime[d] = (eject_dime[d] === 1'b1);
                end else if (plen[d] != 0) begin
                    pop_cmp(d, mk(EV_COIN, pdime[d], plen[d], 0, 0, 0));
                    plen[d] = 0;
                end
                if (busy_prev[d] && busy[d] === 1'b0)
                    pop_cmp(d, mk(EV_DONE, 1'b0, 0, 0, int'(inv_n[d]), int'(inv_d[d])));
                if (!fault_prev[d] && fault[d] === 1'b1)
                    pop_cmp(d, mk(EV_FAULT, 1'b0, 0, int'(owed[d]), int'(inv_n[d]), int'(inv_d[d])));
                busy_prev[d]  = (busy[d] === 1'b1);
                fault_prev[d] = (fault[d] === 1'b1);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit sig_val(int d, int which);
        case (which)
            S_EJN:   return eject_nickel[d];
            S_EJD:   return eject_dime[d];
            S_BUSY:  return busy[d];
            default: return fault[d];
        endcase
    endfunction

    task automatic wait_until(input int d, input int which, input bit level,
                              input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig_val(d, which) == level) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got timeout after %0d cycles, expected level %0d", name, budget, level);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d reset req_ready", d), req_ready[d], 1);
            check($sformatf("dut%0d reset busy", d), busy[d], 0);
            check($sformatf("dut%0d reset fault", d), fault[d], 0);
        end
        check("reset eject_nickel", eject_nickel[0], 0);
        check("reset eject_dime", eject_dime[0], 0);
        check("reset owed", owed[0], 0);
        check("reset nickel_empty", nickel_empty[0], 0);
        check("reset dime_empty", dime_empty[0], 0);
    endtask

    // Leaves the caller one cycle after the handshake edge (SELECT cycle).
    task automatic handshake(input int d, input logic [1:0] chg);
        req_valid[d]  = 1'b1;
        req_change[d] = chg;
        check($sformatf("dut%0d req_ready at handshake", d), req_ready[d], 1);
        tick(1);
        req_valid[d]  = 1'b0;
        req_change[d] = ~chg;
    endtask

    initial begin
        // Test 1: 10c, drop in 2nd EJECT cycle.
        do_reset();
        push_ev(0, mk(EV_COIN, 1'b1, 4, 0, 0, 0));
        push_ev(0, mk(EV_DONE, 1'b0, 0, 0, 20, 19));
        handshake(0, CHG_10);
        check("t1 select no eject", eject_dime[0], 0);
        tick(1);
        check("t1 eject1 dime", eject_dime[0], 1);
        tick(1);
        drop_sense[0] = 1'b1;
        tick(1);
        drop_sense[0] = 1'b0;
        tick(2);
        check("t1 select busy", busy[0], 1);
        tick(1);
        check("t1 idle ready N+7", req_ready[0], 1);

        // Test 2: 15c, drops confirmed in WAIT_DROP.
        do_reset();
        push_ev(0, mk(EV_COIN, 1'b1, 4, 0, 0, 0));
        push_ev(0, mk(EV_COIN, 1'b0, 4, 0, 0, 0));
        push_ev(0, mk(EV_DONE, 1'b0, 0, 0, 19, 19));
        handshake(0, CHG_15);
        wait_until(0, S_EJD, 1'b1, 10, "t2 dime rise");
        wait_until(0, S_EJD, 1'b0, 10, "t2 dime fall");
        tick(2);
        drop_sense[0] = 1'b1;
        tick(1);
        drop_sense[0] = 1'b0;
        check("t2 select after wait busy", busy[0], 1);
        wait_until(0, S_EJN, 1'b1, 10, "t2 nickel rise");
        wait_until(0, S_EJN, 1'b0, 10, "t2 nickel fall");
        tick(1);
        drop_sense[0] = 1'b1;
        tick(1);
        drop_sense[0] = 1'b0;
        check("t2 final select busy", busy[0], 1);
        tick(1);
        check("t2 busy falls", busy[0], 0);

        // Test 3: no dimes, 10c -> two nickels.
        push_ev(1, mk(EV_COIN, 1'b0, 4, 0, 0, 0));
        push_ev(1, mk(EV_COIN, 1'b0, 4, 0, 0, 0));
        push_ev(1, mk(EV_DONE, 1'b0, 0, 0, 18, 0));
        handshake(1, CHG_10);
        for (int i = 0; i < 30 && busy[1]; i++) begin
            check("t3 dime_empty", dime_empty[1], 1);
            drop_sense[1] = eject_nickel[1];
            tick(1);
        end
        drop_sense[1] = 1'b0;
        check("t3 completed", busy[1], 0);

        // Test 4: drop timeout then refill.
        do_reset();
        push_ev(0, mk(EV_COIN, 1'b1, 4, 0, 0, 0));
        push_ev(0, mk(EV_FAULT, 1'b0, 0, 2, 20, 20));
        push_ev(0, mk(EV_COIN, 1'b1, 4, 0, 0, 0));
        push_ev(0, mk(EV_DONE, 1'b0, 0, 0, 20, 19));
        handshake(0, CHG_10);
        wait_until(0, S_EJD, 1'b1, 10, "t4 dime rise");
        wait_until(0, S_EJD, 1'b0, 10, "t4 dime fall");
        tick(15);
        check("t4 no fault at wait 16", fault[0], 0);
        tick(1);
        check("t4 fault", fault[0], 1);
        check("t4 owed", owed[0], 2);
        tick(3);
        check("t4 fault held", fault[0], 1);
        check("t4 no eject in fault", eject_dime[0], 0);
        refill[0] = 1'b1;
        tick(1);
        refill[0] = 1'b0;
        check("t4 fault cleared", fault[0], 0);
        check("t4 busy after refill", busy[0], 1);
        wait_until(0, S_EJD, 1'b1, 10, "t4 refill dime rise");
        drop_sense[0] = 1'b1;
        tick(1);
        drop_sense[0] = 1'b0;
        wait_until(0, S_BUSY, 1'b0, 20, "t4 completion");

        // Test 5: no nickels, 5c -> immediate fault.
        push_ev(2, mk(EV_FAULT, 1'b0, 0, 1, 0, 20));
        check("t5 nickel_empty", nickel_empty[2], 1);
        handshake(2, CHG_5);
        tick(1);
        check("t5 fault", fault[2], 1);
        check("t5 owed", owed[2], 1);
        check("t5 no nickel eject", eject_nickel[2], 0);

        // Zero-value request on dut0.
        handshake(0, CHG_NONE);
        check("t5 zero req busy", busy[0], 0);
        tick(2);
        check("t5 zero req still idle", req_ready[0], 1);

        // Test 6: reset mid-EJECT of a 15c request.
        push_ev(2, mk(EV_DONE, 1'b0, 0, 0, 0, 20));
        push_ev(0, mk(EV_COIN, 1'b1, 2, 0, 0, 0));
        push_ev(0, mk(EV_DONE, 1'b0, 0, 0, 20, 20));
        handshake(0, CHG_15);
        tick(2);
        check("t6 in eject", eject_dime[0], 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6 eject_dime", eject_dime[0], 0);
        check("t6 busy", busy[0], 0);
        check("t6 req_ready", req_ready[0], 1);
        check("t6 nickels", inv_n[0], 20);
        check("t6 dimes", inv_d[0], 20);
        check("t6 dut2 fault cleared", fault[2], 0);

        tick(3);
        check("dut0 queue drained", exp_q0.size(), 0);
        check("dut1 queue drained", exp_q1.size(), 0);
        check("dut2 queue drained", exp_q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
